// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD controller responder.
//   - DDRAM geometry (DDRAM_DEPTH, LINE2_BASE, AC_MAX) and the blank character
//   - instruction class masks (highest set bit of the instruction byte)
//   - FSM state encoding
//   - helpers: cmd_class() and ac_step()
package lcd_pkg;

    localparam int unsigned DDRAM_DEPTH = 80;
    localparam logic [6:0]  LINE2_BASE  = 7'h28;
    localparam logic [6:0]  AC_MAX      = 7'(DDRAM_DEPTH - 1);
    localparam logic [7:0]  BLANK_CHAR  = 8'h20;

    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_ENTRY   = 8'h04;
    localparam logic [7:0] CMD_DISPLAY = 8'h08;
    localparam logic [7:0] CMD_SHIFT   = 8'h10;
    localparam logic [7:0] CMD_FUNC    = 8'h20;
    localparam logic [7:0] CMD_CGRAM   = 8'h40;
    localparam logic [7:0] CMD_DDRAM   = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_BUSY  = 2'd2
    } lcd_state_t;

    // One-hot mask of the highest set bit; CMD_NOP for a zero byte.
    function automatic logic [7:0] cmd_class(input logic [7:0] d);
        logic [7:0] m;
        m = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (d[i]) m = 8'h01 << i;
        end
        return m;
    endfunction

    // Address counter step with wrap over the 80-byte DDRAM.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) return (a >= AC_MAX) ? 7'h00 : a + 7'd1;
        else     return (a == 7'h00)  ? AC_MAX : a - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// lcd_ddram: 80x8 display data RAM.
//   clk       in   clock (rising edge)
//   we        in   write enable for the main port
//   addr      in   main port address (write and combinational read)
//   wdata     in   main port write data
//   rdata     out  main port read data, 0 for out-of-range addresses
//   dbg_addr  in   debug read address
//   dbg_char  out  mem[dbg_addr], registered (one-cycle latency)
// Contents are intentionally not reset.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_char
);

    logic [7:0] mem [DDRAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we && (addr < 7'(DDRAM_DEPTH))) mem[addr] <= wdata;
        dbg_char <= (dbg_addr < 7'(DDRAM_DEPTH)) ? mem[dbg_addr] : '0;
    end

    always_comb begin
        rdata = '0;
        if (addr < 7'(DDRAM_DEPTH)) rdata = mem[addr];
    end

endmodule

// File: rtl/lcd_resp.sv
// lcd_resp: HD44780-style LCD responder model.
// Observes the controller bus (lcd_rs/lcd_rw/lcd_en/lcd_data_in), commits a
// transfer on each lcd_en falling edge, and maintains DDRAM, the address
// counter, the latched instruction fields and the busy flag.
// Ports:
//   lcdclk, resetn (async, active-low)
//   lcd_rs, lcd_rw, lcd_en, lcd_data_in      bus from controller
//   lcd_data_out, lcd_data_oe                read data / drive enable (registered)
//   dbg_addr, dbg_char                       debug DDRAM read, 1-cycle latency
//   busy, ac                                 busy flag, address counter
//   disp_on .. func_2line                    latched instruction fields
//   err_busy, err_addr                       sticky error flags
// Optional feature: define LCD_RESP_READ_EN to enable status/data reads;
// otherwise read outputs stay 0 and rw=1 transfers are ignored.
module lcd_resp
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES  = 37,
    parameter int unsigned CLEAR_CYCLES = 152
) (
    input  logic       lcdclk,
    input  logic       resetn,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_char,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_id,
    output logic       entry_s,
    output logic       func_8bit,
    output logic       func_2line,
    output logic       err_busy,
    output logic       err_addr
);

    localparam logic [15:0] BUSY_LOAD  = 16'(BUSY_CYCLES - 1);
    localparam logic [15:0] CLEAR_LOAD = 16'(CLEAR_CYCLES - 1);

`ifdef LCD_RESP_READ_EN
    localparam logic READ_ON = 1'b1;
`else
    localparam logic READ_ON = 1'b0;
`endif

    lcd_state_t  state;
    logic [15:0] cnt;
    logic [6:0]  fill_idx;
    logic        cgram_sel;
    logic        en_q;
    logic        fall;
    logic        wr_cmd, wr_data, rd_data;
    logic [7:0]  cls;
    logic        fill_we;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    always_comb begin
        fall    = en_q & ~lcd_en;
        wr_cmd  = fall & ~lcd_rs & ~lcd_rw;
        wr_data = fall &  lcd_rs & ~lcd_rw;
        rd_data = fall &  lcd_rs &  lcd_rw & READ_ON;
        cls     = cmd_class(lcd_data_in);
    end

    // The clear fill owns the RAM port; no bus write can be accepted then.
    always_comb begin
        fill_we   = (state == ST_CLEAR) && (fill_idx < 7'(DDRAM_DEPTH));
        mem_we    = fill_we | ((state == ST_IDLE) & wr_data & ~cgram_sel);
        mem_addr  = fill_we ? fill_idx   : ac;
        mem_wdata = fill_we ? BLANK_CHAR : lcd_data_in;
    end

    lcd_ddram u_ddram (
        .clk      (lcdclk),
        .we       (mem_we),
        .addr     (mem_addr),
        .wdata    (mem_wdata),
        .rdata    (mem_rdata),
        .dbg_addr (dbg_addr),
        .dbg_char (dbg_char)
    );

    always_ff @(posedge lcdclk or negedge resetn) begin
        if (!resetn) begin
            en_q <= 1'b0;
        end else begin
            en_q <= lcd_en;
        end
    end

    always_ff @(posedge lcdclk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            cnt        <= '0;
            fill_idx   <= '0;
            ac         <= '0;
            cgram_sel  <= 1'b0;
            disp_on    <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            entry_id   <= 1'b1;
            entry_s    <= 1'b0;
            func_8bit  <= 1'b1;
            func_2line <= 1'b0;
            err_busy   <= 1'b0;
            err_addr   <= 1'b0;
        end else begin
            // Busy is judged on the registered state, so a commit landing on
            // the final busy cycle is still rejected.
            if ((state != ST_IDLE) && (wr_cmd || wr_data || rd_data)) err_busy <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (wr_cmd) begin
                        case (cls)
                            CMD_CLEAR: begin
                                state    <= ST_CLEAR;
                                busy     <= 1'b1;
                                cnt      <= CLEAR_LOAD;
                                fill_idx <= '0;
                                ac       <= '0;
                                entry_id <= 1'b1;
                            end
                            CMD_HOME: ac <= '0;
                            CMD_ENTRY: begin
                                entry_id <= lcd_data_in[1];
                                entry_s  <= lcd_data_in[0];
                            end
                            CMD_DISPLAY: begin
                                disp_on   <= lcd_data_in[2];
                                cursor_on <= lcd_data_in[1];
                                blink_on  <= lcd_data_in[0];
                            end
                            CMD_SHIFT: begin
                                if (!lcd_data_in[3]) ac <= ac_step(ac, lcd_data_in[2]);
                            end
                            CMD_FUNC: begin
                                func_8bit  <= lcd_data_in[4];
                                func_2line <= lcd_data_in[3];
                            end
                            CMD_CGRAM: cgram_sel <= 1'b1;
                            CMD_DDRAM: begin
                                cgram_sel <= 1'b0;
                                if (lcd_data_in[6:0] <= AC_MAX) begin
                                    ac <= lcd_data_in[6:0];
                                end else begin
                                    ac       <= '0;
                                    err_addr <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                        if ((cls != CMD_NOP) && (cls != CMD_CLEAR)) begin
                            state <= ST_BUSY;
                            busy  <= 1'b1;
                            cnt   <= BUSY_LOAD;
                        end
                    end else if (wr_data) begin
                        if (!cgram_sel) ac <= ac_step(ac, entry_id);
                        state <= ST_BUSY;
                        busy  <= 1'b1;
                        cnt   <= BUSY_LOAD;
                    end else if (rd_data) begin
                        ac <= ac_step(ac, entry_id);
                    end
                end
                default: begin
                    if (fill_we) fill_idx <= fill_idx + 7'd1;
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
            endcase
        end
    end

`ifdef LCD_RESP_READ_EN
    always_ff @(posedge lcdclk or negedge resetn) begin
        if (!resetn) begin
            lcd_data_oe  <= 1'b0;
            lcd_data_out <= '0;
        end else begin
            lcd_data_oe  <= lcd_en & lcd_rw;
            if (lcd_en && lcd_rw) lcd_data_out <= lcd_rs ? mem_rdata : {busy, ac};
            else                  lcd_data_out <= '0;
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;

    always_comb begin
        lcd_data_oe  = 1'b0;
        lcd_data_out = '0;
    end
`endif

endmodule

// File: tb/tb_lcd_resp.sv
// tb_lcd_resp: directed self-checking bench for lcd_resp (default parameters).
// Expectations for the read path follow the LCD_RESP_READ_EN macro.
module tb_lcd_resp;

    logic       lcdclk = 1'b0;
    logic       resetn;
    logic       lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data_in;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_char;
    logic       busy;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on, entry_id, entry_s, func_8bit, func_2line;
    logic       err_busy, err_addr;

    int checks = 0;
    int errors = 0;

`ifdef LCD_RESP_READ_EN
    localparam logic RD = 1'b1;
`else
    localparam logic RD = 1'b0;
`endif

    lcd_resp #(.BUSY_CYCLES(37), .CLEAR_CYCLES(152)) dut (
        .lcdclk       (lcdclk),
        .resetn       (resetn),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_en       (lcd_en),
        .lcd_data_in  (lcd_data_in),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe),
        .dbg_addr     (dbg_addr),
        .dbg_char     (dbg_char),
        .busy         (busy),
        .ac           (ac),
        .disp_on      (disp_on),
        .cursor_on    (cursor_on),
        .blink_on     (blink_on),
        .entry_id     (entry_id),
        .entry_s      (entry_s),
        .func_8bit    (func_8bit),
        .func_2line   (func_2line),
        .err_busy     (err_busy),
        .err_addr     (err_addr)
    );

    always #5 lcdclk = ~lcdclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; commit happens on the posedge after lcd_en drops.
    task automatic xfer(input logic r_s, input logic r_w, input logic [7:0] d);
        lcd_rs = r_s; lcd_rw = r_w; lcd_data_in = d; lcd_en = 1'b1;
        @(negedge lcdclk);
        @(negedge lcdclk);
        lcd_en = 1'b0;
        @(negedge lcdclk);
    endtask

    task automatic cmd(input logic [7:0] d);
        xfer(1'b0, 1'b0, d);
    endtask

    task automatic dat(input logic [7:0] d);
        xfer(1'b1, 1'b0, d);
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(negedge lcdclk);
    endtask

    task automatic check_char(input string tag, input logic [6:0] a, input logic [7:0] exp);
        dbg_addr = a;
        @(negedge lcdclk);
        check(tag, {24'h0, dbg_char}, {24'h0, exp});
    endtask

    task automatic measure_busy(output int unsigned n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge lcdclk);
        end
    endtask

    int unsigned nb;

    initial begin
        resetn = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_en = 1'b0;
        lcd_data_in = 8'h00; dbg_addr = 7'h00;
        wait_cyc(3);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_ac", {25'h0, ac}, 32'h0);
        check("rst_entry_id", {31'h0, entry_id}, 32'h1);
        check("rst_func_8bit", {31'h0, func_8bit}, 32'h1);
        check("rst_disp_on", {31'h0, disp_on}, 32'h0);
        check("rst_err_busy", {31'h0, err_busy}, 32'h0);
        check("rst_err_addr", {31'h0, err_addr}, 32'h0);
        check("rst_oe", {31'h0, lcd_data_oe}, 32'h0);
        check("rst_dout", {24'h0, lcd_data_out}, 32'h0);
        resetn = 1'b1;
        wait_cyc(2);

        // Init sequence
        cmd(8'h38);
        measure_busy(nb);
        check("busy_len_cmd", nb, 37);
        wait_cyc(160);
        cmd(8'h0E); wait_cyc(160);
        cmd(8'h06); wait_cyc(160);
        cmd(8'h01);
        measure_busy(nb);
        check("busy_len_clear", nb, 152);
        wait_cyc(10);
        cmd(8'h80); wait_cyc(160);
        check("init_func_2line", {31'h0, func_2line}, 32'h1);
        check("init_func_8bit", {31'h0, func_8bit}, 32'h1);
        check("init_disp_on", {31'h0, disp_on}, 32'h1);
        check("init_cursor_on", {31'h0, cursor_on}, 32'h1);
        check("init_blink_on", {31'h0, blink_on}, 32'h0);
        check("init_entry_id", {31'h0, entry_id}, 32'h1);
        check("init_entry_s", {31'h0, entry_s}, 32'h0);
        check("init_ac", {25'h0, ac}, 32'h0);
        for (int unsigned a = 0; a < 80; a++) check_char("init_blank", 7'(a), 8'h20);

        // "Text" on line 1, "Succ" on line 2
        dat(8'h54); wait_cyc(40);
        dat(8'h65); wait_cyc(40);
        dat(8'h78); wait_cyc(40);
        dat(8'h74); wait_cyc(40);
        cmd(8'hA8); wait_cyc(40);
        dat(8'h53); wait_cyc(40);
        dat(8'h75); wait_cyc(40);
        dat(8'h63); wait_cyc(40);
        dat(8'h63); wait_cyc(40);
        check_char("text0", 7'h00, 8'h54);
        check_char("text1", 7'h01, 8'h65);
        check_char("text2", 7'h02, 8'h78);
        check_char("text3", 7'h03, 8'h74);
        check_char("succ0", 7'h28, 8'h53);
        check_char("succ1", 7'h29, 8'h75);
        check_char("succ2", 7'h2A, 8'h63);
        check_char("succ3", 7'h2B, 8'h63);
        check("text_ac", {25'h0, ac}, 32'h2C);

        // Status read and data write during busy
        cmd(8'h06);
        lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_en = 1'b1;
        @(negedge lcdclk);
        check("status_dout", {24'h0, lcd_data_out}, RD ? 32'hAC : 32'h0);
        check("status_oe", {31'h0, lcd_data_oe}, {31'h0, RD});
        lcd_en = 1'b0;
        @(negedge lcdclk);
        check("status_no_err", {31'h0, err_busy}, 32'h0);
        dat(8'h41);
        check("busy_wr_err", {31'h0, err_busy}, 32'h1);
        check("busy_wr_ac", {25'h0, ac}, 32'h2C);
        wait_cyc(40);
        check_char("busy_wr_mem", 7'h2C, 8'h20);

        // Commit on the last busy cycle is rejected, one cycle later accepted
        cmd(8'h06); wait_cyc(34);
        dat(8'h5A);
        check("last_busy_ac", {25'h0, ac}, 32'h2C);
        wait_cyc(40);
        check_char("last_busy_mem", 7'h2C, 8'h20);
        cmd(8'h06); wait_cyc(35);
        dat(8'h5A);
        check("after_busy_ac", {25'h0, ac}, 32'h2D);
        wait_cyc(40);
        check_char("after_busy_mem", 7'h2C, 8'h5A);

        // AC wrap and address errors
        cmd(8'hCF); wait_cyc(40);
        check("set_4f_ac", {25'h0, ac}, 32'h4F);
        dat(8'h31); wait_cyc(40);
        check("wrap_inc_ac", {25'h0, ac}, 32'h00);
        check_char("wrap_inc_mem", 7'h4F, 8'h31);
        cmd(8'h04); wait_cyc(40);
        check("entry_dec", {31'h0, entry_id}, 32'h0);
        dat(8'h32); wait_cyc(40);
        check("wrap_dec_ac", {25'h0, ac}, 32'h4F);
        check_char("wrap_dec_mem", 7'h00, 8'h32);
        check("pre_err_addr", {31'h0, err_addr}, 32'h0);
        cmd(8'hD5); wait_cyc(40);
        check("bad_addr_ac", {25'h0, ac}, 32'h00);
        check("bad_addr_err", {31'h0, err_addr}, 32'h1);

        // Cursor shift
        cmd(8'h14); wait_cyc(40);
        check("shift_right", {25'h0, ac}, 32'h01);
        cmd(8'h10); wait_cyc(40);
        check("shift_left", {25'h0, ac}, 32'h00);
        cmd(8'h10); wait_cyc(40);
        check("shift_left_wrap", {25'h0, ac}, 32'h4F);
        cmd(8'h1C); wait_cyc(40);
        check("disp_shift_ac", {25'h0, ac}, 32'h4F);

        // CGRAM selection discards data writes
        cmd(8'h40); wait_cyc(40);
        dat(8'h99); wait_cyc(40);
        check("cgram_ac", {25'h0, ac}, 32'h4F);
        check_char("cgram_mem", 7'h4F, 8'h31);
        cmd(8'h80); wait_cyc(40);
        check("ddram_sel_ac", {25'h0, ac}, 32'h00);
        cmd(8'h00);
        check("nop_not_busy", {31'h0, busy}, 32'h0);

        // Data read at 0x28
        cmd(8'h06); wait_cyc(40);
        cmd(8'hA8); wait_cyc(40);
        lcd_rs = 1'b1; lcd_rw = 1'b1; lcd_en = 1'b1;
        @(negedge lcdclk);
        check("read_dout", {24'h0, lcd_data_out}, RD ? 32'h53 : 32'h0);
        check("read_oe", {31'h0, lcd_data_oe}, {31'h0, RD});
        lcd_en = 1'b0;
        @(negedge lcdclk);
        check("read_ac", {25'h0, ac}, RD ? 32'h29 : 32'h28);
        check("read_not_busy", {31'h0, busy}, 32'h0);
        @(negedge lcdclk);
        check("read_oe_off", {31'h0, lcd_data_oe}, 32'h0);

        // Reset during clear fill
        cmd(8'h14); wait_cyc(40);
        cmd(8'h01); wait_cyc(10);
        check("clear_busy", {31'h0, busy}, 32'h1);
        resetn = 1'b0;
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_ac", {25'h0, ac}, 32'h0);
        @(negedge lcdclk);
        resetn = 1'b1;
        @(negedge lcdclk);
        check("abort_idle", {31'h0, busy}, 32'h0);
        check_char("abort_filled", 7'h00, 8'h20);
        check_char("abort_kept", 7'h28, 8'h53);
        check("abort_no_err", {31'h0, err_busy}, 32'h0);
        cmd(8'h14);
        check("post_abort_accept", {25'h0, ac}, 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_resp.md
LCD_RESP -- requirements
Module: lcd_resp

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 37: lcdclk cycles busy after a non-clear command or data write.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 152 (minimum 80): total lcdclk cycles busy after clear-display.
REQ-003 lcdclk  in  1  clock; all logic on rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 lcd_rs  in  1  register select: 0=instruction/status, 1=data.
REQ-006 lcd_rw  in  1  0=write, 1=read.
REQ-007 lcd_en  in  1  enable strobe; a transfer commits on its falling edge.
REQ-008 lcd_data_in  in  8  bus value from the controller.
REQ-009 lcd_data_out  out  8  read data returned to the controller.
REQ-010 lcd_data_oe  out  1  read-drive enable.
REQ-011 dbg_addr  in  7  debug DDRAM read address.
REQ-012 dbg_char  out  8  DDRAM[dbg_addr], one-cycle registered latency.
REQ-013 busy  out  1  busy flag; ac  out  7  address counter.
REQ-014 disp_on, cursor_on, blink_on, entry_id, entry_s, func_8bit, func_2line  out  1 each  latched instruction fields.
REQ-015 err_busy, err_addr  out  1 each  sticky error flags.

Function
REQ-016 SHALL detect an lcd_en falling edge by comparing lcd_en with a one-cycle registered copy, then sample lcd_rs, lcd_rw and lcd_data_in in that same cycle.
REQ-017 SHALL implement DDRAM as 80 bytes, linear addresses 0x00-0x4F; line 1 starts at 0x00, line 2 at 0x28.
REQ-018 SHALL have FSM states ST_IDLE, ST_CLEAR, ST_BUSY; busy=1 in ST_CLEAR and ST_BUSY.
REQ-019 Instruction decode (rs=0, rw=0), by highest set bit:
- 0x01: enter ST_CLEAR; write 0x20 to addresses 0..79, one per cycle; AC=0; entry_id=1; busy for CLEAR_CYCLES.
- 0x02/0x03: AC=0.
- 0x04-0x07: entry_id=d[1], entry_s=d[0].
- 0x08-0x0F: disp_on=d[2], cursor_on=d[1], blink_on=d[0].
- 0x10-0x1F: if d[3]=0, AC moves +1 when d[2]=1, -1 when d[2]=0; display shift (d[3]=1) makes no change.
- 0x20-0x3F: func_8bit=d[4], func_2line=d[3].
- 0x40-0x7F: CGRAM selected; subsequent data writes discarded until the next DDRAM-address set.
- 0x80-0xFF: DDRAM selected; AC=d[6:0] if <=0x4F, else AC=0 and err_addr=1.
- 0x00: no operation, no busy.
REQ-020 Data write (rs=1, rw=0): DDRAM[AC]=data; AC increments if entry_id=1, else decrements.
REQ-021 AC SHALL wrap 0x4F->0x00 on increment and 0x00->0x4F on decrement.
REQ-022 Every accepted command other than clear and 0x00, and every data write, SHALL enter ST_BUSY for exactly BUSY_CYCLES cycles, then return to ST_IDLE.
REQ-023 A write or data read committed while busy=1 SHALL be discarded with no state change, and SHALL set err_busy.
REQ-024 Status read (rs=0, rw=1) SHALL be accepted in any state: lcd_data_out={busy,ac} while lcd_en=1.
REQ-025 Data read (rs=1, rw=1) while not busy: lcd_data_out=DDRAM[AC] while lcd_en=1; AC advances per entry_id on the falling edge; busy is not set.
REQ-026 lcd_data_oe SHALL equal lcd_en & lcd_rw, registered, with one-cycle latency.
REQ-027 Falling-edge detection and the last cycle of BUSY_CYCLES coinciding SHALL count as busy, so the transfer is discarded.

Reset
REQ-028 Reset values: lcd_data_out=0, lcd_data_oe=0, busy=0, ac=0, disp_on=0, cursor_on=0, blink_on=0, entry_id=1, entry_s=0, func_8bit=1, func_2line=0, err_busy=0, err_addr=0, FSM=ST_IDLE, DDRAM selected.
REQ-029 Reset asserted mid-clear SHALL abort the fill; DDRAM contents are not reset.

Configuration
REQ-030 With macro LCD_RESP_READ_EN defined, the read path works as in REQ-024/025/026. Without it, lcd_data_out=0 and lcd_data_oe=0 always, and rw=1 transfers are ignored, with no AC change.

Structure
REQ-031 Package lcd_pkg SHALL hold opcode masks, FSM state encoding, DDRAM_DEPTH=80, LINE2_BASE=0x28 and the blank character 0x20.
REQ-032 DDRAM SHALL be sub-module lcd_ddram: 80x8, with one read/write port and one registered debug read port.

Verification
REQ-033 Reset, then 0x38, 0x0E, 0x06, 0x01, 0x80 (each spaced > CLEAR_CYCLES) -> func_2line=1, disp_on=1, cursor_on=1, entry_id=1, ac=0, all dbg_char=0x20.
REQ-034 Data "Text" at AC=0, then 0xA8 and "Succ" -> dbg_char[0..3]=54 65 78 74, dbg_char[0x28..0x2B]=53 75 63 63, ac=0x2C.
REQ-035 Data write 2 cycles after a previous command -> write discarded, err_busy=1; a status read in the same window returns bit7=1.
REQ-036 0x80|0x4F, then 0x06 and one data byte -> ac=0x00; 0x04 at AC=0 and one data byte -> ac=0x4F; 0xD5 -> ac=0, err_addr=1.
REQ-037 Data read at AC=0x28 with the LCD_RESP_READ_EN macro defined -> lcd_data_out=0x53 with oe=1, ac=0x29 afterwards. Without the macro -> oe stays 0 and ac stays 0x28.
REQ-038 resetn pulsed during the clear fill -> busy=0, ac=0, FSM=ST_IDLE on the next cycle.
